// File: rtl/round_robin_addr_gen.sv
// Four-channel round-robin arbiter that drives a 2-to-4 decoder (en/addr).
// A grant is held until done, loss of request, or MAX_HOLD cycles, then one idle cycle follows.
module round_robin_addr_gen #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic       en,
  output logic [1:0] addr,
  output logic       timeout
);

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  logic       state;
  logic [7:0] hold_cnt;
  logic [1:0] ptr;
  logic [1:0] winner;
  logic       at_limit;
  logic       normal_rel;

  // Search downward so the channel just above ptr is assigned last and wins;
  // offset 4 wraps to ptr itself, giving the last-granted channel lowest priority.
  always_comb begin
    winner = ptr;
    for (int i = 4; i >= 1; i--) begin
      if (req[ptr + 2'(i)]) winner = ptr + 2'(i);
    end
  end

  assign at_limit   = (hold_cnt == HOLD_LIMIT);
  assign normal_rel = done | ~req[addr];
  assign en         = (state == GRANT);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let later statements see updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= 2'b00;
      timeout  <= 1'b0;
      hold_cnt <= 8'd0;
      ptr      <= 2'd3;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state    <= GRANT;
          addr     <= winner;
          ptr      <= winner;
          hold_cnt <= 8'd1;
        end
      end else begin
        if (normal_rel || at_limit) begin
          state    <= IDLE;
          hold_cnt <= 8'd0;
          // A normal release takes precedence over the hold limit.
          timeout  <= at_limit && !normal_rel;
        end else begin
          hold_cnt <= hold_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_round_robin_addr_gen.sv
// Scoreboard bench: stimulus pushes expected grants (addr, length, timeout);
// a negedge monitor measures each grant the DUT issues and compares.
module tb_round_robin_addr_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic       en;
  logic [1:0] addr;
  logic       timeout;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] len;
    logic       to;
  } grant_t;

  grant_t exp_q[$];
  int total = 0;
  int bad   = 0;

  round_robin_addr_gen #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .en(en), .addr(addr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input logic [1:0] a, input int len, input logic to);
    exp_q.push_back('{addr: a, len: 8'(len), to: to});
  endtask

  // Monitor: measures each en-high run and checks it against the queue head.
  logic       in_grant = 1'b0;
  logic [1:0] g_addr = 2'b00;
  int         g_len = 0;
  grant_t     e;

  always @(negedge clk) begin
    if (en === 1'b1) begin
      if (!in_grant) begin
        in_grant = 1'b1;
        g_addr   = addr;
        g_len    = 0;
      end
      g_len++;
    end else if (in_grant) begin
      in_grant = 1'b0;
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("grant_addr", int'(g_addr), int'(e.addr));
        check("grant_len", g_len, int'(e.len));
        check("grant_timeout", int'(timeout), int'(e.to));
      end
    end else if (rst === 1'b0) begin
      check("idle_timeout", int'(timeout), 0);
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_en", int'(en), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_timeout", int'(timeout), 0);
    rst = 1'b0;

    // All requesting, done each first cycle: 0,1,2,3,0 from reset ptr=3
    expect_grant(2'd0, 1, 1'b0);
    expect_grant(2'd1, 1, 1'b0);
    expect_grant(2'd2, 1, 1'b0);
    expect_grant(2'd3, 1, 1'b0);
    expect_grant(2'd0, 1, 1'b0);
    req = 4'b1111; done = 1'b1;
    repeat (10) tick();
    req = 4'b0000; done = 1'b0;
    tick();
    check("idle_en", int'(en), 0);
    check("idle_addr_hold", int'(addr), 0);

    // req=1001 with ptr=0: 3,0,3,0
    expect_grant(2'd3, 1, 1'b0);
    expect_grant(2'd0, 1, 1'b0);
    expect_grant(2'd3, 1, 1'b0);
    expect_grant(2'd0, 1, 1'b0);
    req = 4'b1001; done = 1'b1;
    repeat (8) tick();
    req = 4'b0000; done = 1'b0;
    tick();

    // Single persistent requester: 8-cycle grants ending in timeout, re-granted
    expect_grant(2'd2, 8, 1'b1);
    expect_grant(2'd2, 8, 1'b1);
    req = 4'b0100;
    repeat (18) tick();
    req = 4'b0000;
    tick();

    // Grant to 1 (ptr=2), req[1] drops in cycle 3, next grant goes to 2
    expect_grant(2'd1, 3, 1'b0);
    expect_grant(2'd2, 1, 1'b0);
    req = 4'b0110;
    repeat (3) tick();
    req = 4'b0100;
    repeat (2) tick();
    done = 1'b1;
    tick();
    req = 4'b0000; done = 1'b0;
    tick();

    // done coincides with the hold limit: normal release, no timeout
    expect_grant(2'd2, 8, 1'b0);
    req = 4'b0100;
    repeat (8) tick();
    done = 1'b1;
    tick();
    req = 4'b0000; done = 1'b0;
    tick();

    // Reset mid-grant on addr 2, then first grant searches from 0
    expect_grant(2'd2, 1, 1'b0);
    req = 4'b0100;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("midrst_en", int'(en), 0);
    check("midrst_addr", int'(addr), 0);
    check("midrst_timeout", int'(timeout), 0);
    req = 4'b1100;
    repeat (2) tick();
    rst = 1'b0;
    expect_grant(2'd2, 1, 1'b0);
    tick();
    check("post_rst_grant_en", int'(en), 1);
    done = 1'b1;
    tick();
    req = 4'b0000; done = 1'b0;
    repeat (3) tick();

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
